// File: rtl/regfile_dump_reader_if.sv
// Register-file dump stream interface.
// Groups the read port toward the register file (Ra out, busA back) and the
// valid/ready word stream (out_valid, out_ready, out_data, out_addr, out_last).
//   master : the dump engine (drives Ra and the stream, samples busA/out_ready)
//   slave  : the register file plus word consumer
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Ra;
  logic [DATA_W-1:0] busA;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output Ra,
    input  busA,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  Ra,
    output busA,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Read-side engine that walks an inclusive, wrap-around range of register
// addresses through one combinational read port and streams each word with
// its register number over valid/ready. It never writes the register file.
// Ports:
//   CLK        clock, all state changes on posedge
//   RST_N      asynchronous active-low reset
//   start      begin a dump (only honoured in IDLE)
//   first_addr first register of the range, taken on an accepted start
//   last_addr  last register of the range (inclusive), taken on accepted start
//   abort      synchronous cancel of a running dump (LOAD/SEND only)
//   bus        master side: Ra/busA read port and the word stream
//   busy       dump in progress (LOAD or SEND)
//   done       one-cycle pulse after the final word is accepted
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      first_addr,
  input  logic [ADDR_W-1:0]      last_addr,
  input  logic                   abort,
  regfile_dump_reader_if.master  bus,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ra;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_ra_nxt;
  logic [ADDR_W-1:0]   w_last_addr_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic [ADDR_W-1:0]   w_out_addr_nxt;
  logic                w_out_valid_nxt;
  logic                w_out_last_nxt;
  logic                w_hs;

  assign w_hs = r_out_valid & bus.out_ready;

  // Next-state and next-output logic. Capturing a word always takes busA for
  // the current Ra and then advances Ra, so the read port is already pointing
  // at the following register while the captured word waits for the consumer.
  always_comb begin
    w_state_nxt     = r_state;
    w_ra_nxt        = r_ra;
    w_last_addr_nxt = r_last_addr;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;

    case (r_state)
      S_IDLE: begin
        // start wins over a coincident abort; abort means nothing here
        if (start) begin
          w_last_addr_nxt = last_addr;
          w_ra_nxt        = first_addr;
          w_state_nxt     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_out_data_nxt  = bus.busA;
          w_out_addr_nxt  = r_ra;
          w_out_last_nxt  = (r_ra == r_last_addr);
          w_out_valid_nxt = 1'b1;
          w_ra_nxt        = r_ra + ADDR_W'(1);
          w_state_nxt     = S_SEND;
        end
      end

      S_SEND: begin
        // abort outranks a coincident handshake: that word counts as not sent
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (w_hs) begin
          if (r_out_last) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_state_nxt     = S_DONE;
          end else begin
            w_out_data_nxt  = bus.busA;
            w_out_addr_nxt  = r_ra;
            w_out_last_nxt  = (r_ra == r_last_addr);
            w_ra_nxt        = r_ra + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State register; busy/done are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_ra        <= '0;
      r_last_addr <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ra        <= w_ra_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SEND);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.Ra        = r_ra;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: directed dumps plus randomized ranges,
// register contents and consumer back-pressure, checked against a simple
// address-sequence model of the dump.
module tb_regfile_dump_reader;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        abort;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];

  int errors = 0;
  int checks = 0;

  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  // Register file read port: combinational
  assign bus.busA = regs[bus.Ra];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One dump of [f..l] with wrap. mode: 0 ready always, 1 ready pattern 1,0,0,
  // 2 random ready. abort_word>=0 aborts during a stall at that word index.
  // hold_start keeps start high throughout. write_word>=0 writes reg[10]
  // during a stall at that word index.
  task automatic dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                      input int abort_word, input bit hold_start, input int write_word);
    logic [4:0] span;
    logic [4:0] a;
    logic       rdy;
    int         n;
    int         idx;
    int         cyc;
    int         pat;
    bit         wrote;
    span = l - f;
    n = int'(span) + 1;
    @(negedge CLK);
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    if (!hold_start) start = 1'b0;
    chk("load_busy", {31'b0, busy}, 32'd1);
    chk("load_valid", {31'b0, bus.out_valid}, 32'd0);
    idx = 0;
    cyc = 0;
    pat = 0;
    wrote = 0;
    while (idx < n && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      a = f + 5'(idx);
      chk("send_busy", {31'b0, busy}, 32'd1);
      chk("send_done", {31'b0, done}, 32'd0);
      chk("send_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("word_addr", {27'b0, bus.out_addr}, {27'b0, a});
      chk("word_data", bus.out_data, regs[a]);
      chk("word_last", {31'b0, bus.out_last}, {31'b0, (idx == n - 1)});
      if (write_word >= 0 && a == 5'd10 && wrote)
        chk("written_word10", bus.out_data, 32'hDEADBEEF);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pat % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pat++;
      if (write_word >= 0 && !wrote && idx == write_word && !rdy) begin
        regs[10] = 32'hDEADBEEF;
        wrote = 1;
      end
      if (abort_word >= 0 && idx == abort_word && !rdy) begin
        bus.out_ready = 1'b0;
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort_last", {31'b0, bus.out_last}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(negedge CLK);
        chk("abort_no_done", {31'b0, done}, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        return;
      end
      bus.out_ready = rdy;
      if (rdy) idx++;
    end
    chk("word_count", idx, n);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("done_last", {31'b0, bus.out_last}, 32'd0);
    @(negedge CLK);
    chk("done_cleared", {31'b0, done}, 32'd0);
    chk("idle_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    first_addr = '0;
    last_addr = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);

    #2;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_addr", {27'b0, bus.out_addr}, 32'd0);
    chk("rst_ra", {27'b0, bus.Ra}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Full register file, no back-pressure
    dump(5'd0, 5'd31, 0, -1, 1'b0, -1);
    // Wrapping range with stalls
    dump(5'd30, 5'd1, 1, -1, 1'b0, -1);
    // Single word
    dump(5'd7, 5'd7, 0, -1, 1'b0, -1);
    // Abort while stalled on word 5, then a normal dump
    dump(5'd0, 5'd31, 1, 5, 1'b0, -1);
    dump(5'd0, 5'd3, 0, -1, 1'b0, -1);

    // start held high through a 0..3 dump: start ignored until IDLE
    dump(5'd0, 5'd3, 0, -1, 1'b1, -1);
    @(negedge CLK);
    chk("restart_after_done", {31'b0, busy}, 32'd1);
    start = 1'b0;
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_in_load_busy", {31'b0, busy}, 32'd0);
    chk("abort_in_load_valid", {31'b0, bus.out_valid}, 32'd0);

    // Register write while stalled at word 4 shows up in word 10
    dump(5'd0, 5'd15, 1, -1, 1'b0, 4);
    regs[10] = 32'd10;

    // Reset mid-SEND; also start+abort in IDLE (start wins)
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    first_addr = 5'd0;
    last_addr = 5'd31;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", {31'b0, busy}, 32'd1);
    @(negedge CLK);
    chk("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_data", bus.out_data, 32'd0);
    chk("mid_rst_addr", {27'b0, bus.out_addr}, 32'd0);
    chk("mid_rst_last", {31'b0, bus.out_last}, 32'd0);
    chk("mid_rst_ra", {27'b0, bus.Ra}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Randomized contents, ranges and back-pressure
    for (int k = 0; k < 4; k++) begin
      logic [4:0] rf;
      logic [4:0] rl;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rf = 5'($urandom_range(0, 31));
      rl = 5'($urandom_range(0, 31));
      dump(rf, rl, 2, -1, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
